// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: datapath defaults, write-back
// source encoding and halt FSM states.
package wb_pkg;

  localparam int DATA_W_DFLT = 16;
  localparam int REG_AW_DFLT = 4;
  localparam int DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC2 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } halt_state_e;

endpackage

// File: rtl/wb_halt_fsm.sv
// Halt sequencer: after a halt is captured, drains for DRAIN_CYCLES cycles
// and then parks in HALTED until reset.
module wb_halt_fsm
  import wb_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_halt,
  output halt_state_e state,
  output logic        halted
);

  halt_state_e            state_next;
  logic [DRAIN_CNT_W-1:0] cnt;
  logic [DRAIN_CNT_W-1:0] cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first so every path assigns every output (no latches).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (capture_halt) begin
          state_next = DRAIN;
          cnt_next   = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt == '0) state_next = HALTED;
        else           cnt_next   = cnt - 1'b1;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  assign halted = (state == HALTED);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, selects the write-back value and
// drives the register-file write port. Optional macro WB_RETIRE_COUNT_EN adds
// a 32-bit retired-instruction counter output.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int REG_AW       = REG_AW_DFLT,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_wen,
  input  logic [REG_AW-1:0] mem_dst_reg,
  input  logic [1:0]        mem_wb_sel,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_pc_plus2,
  input  logic              mem_halt,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              wb_valid,
`ifdef WB_RETIRE_COUNT_EN
  output logic [31:0]       retire_count,
`endif
  output logic              halted
);

  logic              valid_r;
  logic              wen_r;
  logic              halt_r;
  logic [REG_AW-1:0] dst_r;
  logic [1:0]        sel_r;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] rdata_r;
  logic [DATA_W-1:0] pc2_r;

  halt_state_e state;
  logic        is_halted;
  logic        capture;

  // A real capture: not halted, not squashed, not frozen.
  assign capture = !is_halted && !wb_flush && !wb_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      wen_r   <= 1'b0;
      halt_r  <= 1'b0;
      dst_r   <= '0;
      sel_r   <= '0;
      alu_r   <= '0;
      rdata_r <= '0;
      pc2_r   <= '0;
    end else if (!is_halted) begin
      if (wb_flush) begin
        valid_r <= 1'b0;
      end else if (!wb_stall) begin
        valid_r <= mem_valid;
        wen_r   <= mem_reg_wen;
        halt_r  <= mem_halt;
        dst_r   <= mem_dst_reg;
        sel_r   <= mem_wb_sel;
        alu_r   <= mem_alu_result;
        rdata_r <= mem_rdata;
        pc2_r   <= mem_pc_plus2;
      end
    end
  end

  always_comb begin
    rf_write_data = alu_r;
    case (sel_r)
      WB_MEM:  rf_write_data = rdata_r;
      WB_PC2:  rf_write_data = pc2_r;
      default: rf_write_data = alu_r;
    endcase
  end

  wb_halt_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_fsm (
    .clk          (clk),
    .rst          (rst),
    .capture_halt (capture && mem_valid && mem_halt),
    .state        (state),
    .halted       (is_halted)
  );

  // HLT never writes, and R0 is hardwired so writes to it are dropped.
  assign rf_write_en  = valid_r && wen_r && !halt_r && (dst_r != '0) && (state != HALTED);
  assign rf_write_reg = dst_r;
  assign wb_valid     = valid_r && !is_halted;
  assign halted       = is_halted;

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                         retire_count <= '0;
    else if (capture && mem_valid)   retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table plus hand-written halt and
// reset sequences, expectations queued at drive time and popped after the edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_wen, mem_halt, wb_stall, wb_flush;
  logic [3:0]  mem_dst_reg;
  logic [1:0]  mem_wb_sel;
  logic [15:0] mem_alu_result, mem_rdata, mem_pc_plus2;
  logic [3:0]  rf_write_reg;
  logic [15:0] rf_write_data;
  logic        rf_write_en, wb_valid, halted;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
  logic [31:0] rc_before;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_wen    (mem_reg_wen),
    .mem_dst_reg    (mem_dst_reg),
    .mem_wb_sel     (mem_wb_sel),
    .mem_alu_result (mem_alu_result),
    .mem_rdata      (mem_rdata),
    .mem_pc_plus2   (mem_pc_plus2),
    .mem_halt       (mem_halt),
    .wb_stall       (wb_stall),
    .wb_flush       (wb_flush),
    .rf_write_reg   (rf_write_reg),
    .rf_write_data  (rf_write_data),
    .rf_write_en    (rf_write_en),
    .wb_valid       (wb_valid),
`ifdef WB_RETIRE_COUNT_EN
    .retire_count   (retire_count),
`endif
    .halted         (halted)
  );

  typedef struct {
    logic        rst, valid, wen, halt, stall, flush;
    logic [3:0]  dst;
    logic [1:0]  sel;
    logic [15:0] alu, rdata, pc2;
    logic        e_en;
    logic [3:0]  e_reg;
    logic [15:0] e_data;
    logic        e_valid, e_halted;
    logic        chk_rd;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   step_no = 0;

  function automatic vec_t mk(logic r, logic v, logic w, logic h, logic s, logic f,
                              logic [3:0] d, logic [1:0] sl, logic [15:0] a,
                              logic [15:0] rd, logic [15:0] p,
                              logic ee, logic [3:0] er, logic [15:0] ed,
                              logic ev, logic eh, logic c);
    vec_t x;
    x.rst = r; x.valid = v; x.wen = w; x.halt = h; x.stall = s; x.flush = f;
    x.dst = d; x.sel = sl; x.alu = a; x.rdata = rd; x.pc2 = p;
    x.e_en = ee; x.e_reg = er; x.e_data = ed; x.e_valid = ev; x.e_halted = eh;
    x.chk_rd = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst; mem_valid = v.valid; mem_reg_wen = v.wen; mem_halt = v.halt;
    wb_stall = v.stall; wb_flush = v.flush; mem_dst_reg = v.dst; mem_wb_sel = v.sel;
    mem_alu_result = v.alu; mem_rdata = v.rdata; mem_pc_plus2 = v.pc2;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    step_no++;
    check($sformatf("step%0d en", step_no), {31'd0, rf_write_en}, {31'd0, e.e_en});
    check($sformatf("step%0d valid", step_no), {31'd0, wb_valid}, {31'd0, e.e_valid});
    check($sformatf("step%0d halted", step_no), {31'd0, halted}, {31'd0, e.e_halted});
    if (e.chk_rd) begin
      check($sformatf("step%0d reg", step_no), {28'd0, rf_write_reg}, {28'd0, e.e_reg});
      check($sformatf("step%0d data", step_no), {16'd0, rf_write_data}, {16'd0, e.e_data});
    end
  endtask

  initial begin
    // Reset for two cycles with live-looking inputs; everything must read 0.
    tbl.push_back(mk(1,1,1,0,0,0, 4'd3, 2'b00, 16'h1234, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(1,1,1,0,0,0, 4'd3, 2'b00, 16'h1234, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 1));
    // ALU write and the other mux sources.
    tbl.push_back(mk(0,1,1,0,0,0, 4'd3, 2'b00, 16'h1234, 16'h5555, 16'h6666, 1, 4'd3, 16'h1234, 1, 0, 1));
    tbl.push_back(mk(0,1,1,0,0,0, 4'd5, 2'b01, 16'h9999, 16'hBEEF, 16'h6666, 1, 4'd5, 16'hBEEF, 1, 0, 1));
    tbl.push_back(mk(0,1,1,0,0,0, 4'd5, 2'b10, 16'h9999, 16'hBEEF, 16'h0042, 1, 4'd5, 16'h0042, 1, 0, 1));
    tbl.push_back(mk(0,1,1,0,0,0, 4'd5, 2'b11, 16'h0007, 16'hBEEF, 16'h0042, 1, 4'd5, 16'h0007, 1, 0, 1));
    // R0 suppression, invalid capture, flush, stall+flush, wen=0.
    tbl.push_back(mk(0,1,1,0,0,0, 4'd0, 2'b00, 16'h1111, 16'h0, 16'h0, 0, 4'd0, 16'h1111, 1, 0, 1));
    tbl.push_back(mk(0,0,1,0,0,0, 4'd6, 2'b00, 16'h2222, 16'h0, 16'h0, 0, 4'd6, 16'h2222, 0, 0, 1));
    tbl.push_back(mk(0,1,1,0,0,1, 4'd8, 2'b00, 16'h3333, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0,1,1,0,0,0, 4'd9, 2'b00, 16'h4444, 16'h0, 16'h0, 1, 4'd9, 16'h4444, 1, 0, 1));
    tbl.push_back(mk(0,1,1,0,1,1, 4'd13,2'b00, 16'hDDDD, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 4'd4, 2'b00, 16'h0404, 16'h0, 16'h0, 0, 4'd4, 16'h0404, 1, 0, 1));
    // A flushed halt must not start the drain.
    tbl.push_back(mk(0,1,0,1,0,1, 4'd0, 2'b00, 16'h0000, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,0,0,0, 4'd1, 2'b00, 16'h0A00 + 16'(i), 16'h0, 16'h0,
                       1, 4'd1, 16'h0A00 + 16'(i), 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Stall hold: capture 7/0x00AA, then three stalled cycles with changing inputs.
`ifdef WB_RETIRE_COUNT_EN
    rc_before = retire_count;
`endif
    apply(mk(0,1,1,0,0,0, 4'd7, 2'b00, 16'h00AA, 16'h0, 16'h0, 1, 4'd7, 16'h00AA, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      apply(mk(0,1,1,0,1,0, 4'd12 + 4'(i), 2'b01, 16'hF0F0, 16'hFFFF, 16'hEEEE,
               1, 4'd7, 16'h00AA, 1, 0, 1));
`ifdef WB_RETIRE_COUNT_EN
    check("retire_delta", retire_count - rc_before, 32'd1);
`endif

    // Halt drain: HLT with wen=1 captured at edge E, then an older-style ALU write.
    apply(mk(0,1,1,1,0,0, 4'd2, 2'b00, 16'h5555, 16'h0, 16'h0, 0, 4'd2, 16'h5555, 1, 0, 1));
    apply(mk(0,1,1,0,0,0, 4'd10,2'b00, 16'h6666, 16'h0, 16'h0, 1, 4'd10,16'h6666, 1, 0, 1));
    apply(mk(0,1,1,0,0,0, 4'd11,2'b00, 16'h7777, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      apply(mk(0,1,1,0,0,0, 4'd3, 2'b00, 16'h8888, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 1, 0));

    // Reset mid-drain, then normal writes must resume and no halt may follow.
    apply(mk(1,0,0,0,0,0, 4'd0, 2'b00, 16'h0000, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 1));
    apply(mk(0,1,1,1,0,0, 4'd2, 2'b00, 16'h5555, 16'h0, 16'h0, 0, 4'd2, 16'h5555, 1, 0, 1));
    apply(mk(1,1,1,0,0,0, 4'd6, 2'b00, 16'h1212, 16'h0, 16'h0, 0, 4'd0, 16'h0000, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      apply(mk(0,1,1,0,0,0, 4'd14, 2'b10, 16'h0, 16'h0, 16'h0100 + 16'(i),
               1, 4'd14, 16'h0100 + 16'(i), 1, 0, 1));
`ifdef WB_RETIRE_COUNT_EN
    check("retire_after_reset", retire_count, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
